// File: rtl/spot_actuator_if.sv
// Spotlight command bus (SPO) and actuator status signals.
// The master side drives SPO; the actuator (slave) drives the motor, lamp and status lines.
interface spot_actuator_if;
  logic [2:0] SPO;
  logic       step;
  logic       dir;
  logic [3:0] lamp;
  logic       busy;
  logic [1:0] at_pos;
  logic       fault;

  modport master (
    output SPO,
    input  step, dir, lamp, busy, at_pos, fault
  );

  modport slave (
    input  SPO,
    output step, dir, lamp, busy, at_pos, fault
  );
endinterface

// File: rtl/spot_actuator.sv
// Spotlight actuator: decodes SPO into motor step/dir pulses between Left/Center/Right,
// ramps lamp brightness, and reports the reached position and invalid position codes.
module spot_actuator #(
  parameter int STEPS_PER_POS = 8,
  parameter int STEP_DIV      = 4,
  parameter int SETTLE_CYC    = 3,
  parameter int LAMP_MAX      = 15,
  parameter int RAMP_DIV      = 2
) (
  input  logic            clk,
  input  logic            rst,
  spot_actuator_if.slave  bus
);

  localparam int PMAX = 2 * STEPS_PER_POS;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int DW   = $clog2(STEP_DIV);
  localparam int SW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [PW-1:0] POS_L = '0;
  localparam logic [PW-1:0] POS_C = PW'(STEPS_PER_POS);
  localparam logic [PW-1:0] POS_R = PW'(PMAX);

  typedef enum logic [1:0] {
    IDLE,
    STEP_HI,
    STEP_LO,
    SETTLE
  } state_t;

  state_t        state, state_d;
  logic [2:0]    cmd_q;
  logic [PW-1:0] tgt;
  logic [PW-1:0] pos, pos_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] div_cnt, div_d;
  logic [SW-1:0] set_cnt, set_d;
  logic [1:0]    at_pos_q, at_pos_d;
  logic [3:0]    lamp_q, lamp_tgt;
  logic [RW-1:0] ramp_cnt;

  function automatic logic [1:0] pos_code(input logic [PW-1:0] p);
    if (p == POS_L)      return 2'b00;
    else if (p == POS_C) return 2'b01;
    else                 return 2'b11;
  endfunction

  // Command register and target decode; code 10 leaves the target where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= 3'b001;
      tgt   <= POS_C;
    end else begin
      cmd_q <= bus.SPO;
      case (cmd_q[1:0])
        2'b00:   tgt <= POS_L;
        2'b01:   tgt <= POS_C;
        2'b11:   tgt <= POS_R;
        default: tgt <= tgt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pos      <= POS_C;
      dir_q    <= 1'b0;
      div_cnt  <= '0;
      set_cnt  <= '0;
      at_pos_q <= 2'b01;
    end else begin
      state    <= state_d;
      pos      <= pos_d;
      dir_q    <= dir_d;
      div_cnt  <= div_d;
      set_cnt  <= set_d;
      at_pos_q <= at_pos_d;
    end
  end

  // Retarget decisions happen only in IDLE or on the last clock of a step period.
  always_comb begin
    state_d  = state;
    pos_d    = pos;
    dir_d    = dir_q;
    div_d    = div_cnt;
    set_d    = set_cnt;
    at_pos_d = at_pos_q;
    case (state)
      IDLE: begin
        if (tgt != pos) begin
          dir_d   = (tgt > pos);
          state_d = STEP_HI;
        end
      end
      STEP_HI: begin
        pos_d   = dir_q ? (pos + 1'b1) : (pos - 1'b1);
        div_d   = '0;
        state_d = STEP_LO;
      end
      STEP_LO: begin
        if (div_cnt == DW'(STEP_DIV - 2)) begin
          if (tgt != pos) begin
            dir_d   = (tgt > pos);
            state_d = STEP_HI;
          end else begin
            set_d   = '0;
            state_d = SETTLE;
          end
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (set_cnt == SW'(SETTLE_CYC - 1)) begin
          at_pos_d = pos_code(pos);
          state_d  = IDLE;
        end else begin
          set_d = set_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lamp ramp: divider only runs while away from target, so no overshoot or wrap.
  assign lamp_tgt = cmd_q[2] ? 4'(LAMP_MAX) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q   <= '0;
      ramp_cnt <= '0;
    end else if (lamp_q == lamp_tgt) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == RW'(RAMP_DIV - 1)) begin
      ramp_cnt <= '0;
      lamp_q   <= (lamp_q < lamp_tgt) ? (lamp_q + 1'b1) : (lamp_q - 1'b1);
    end else begin
      ramp_cnt <= ramp_cnt + 1'b1;
    end
  end

  assign bus.step   = (state == STEP_HI);
  assign bus.dir    = dir_q;
  assign bus.lamp   = lamp_q;
  assign bus.busy   = (state != IDLE);
  assign bus.at_pos = at_pos_q;
  assign bus.fault  = (cmd_q[1:0] == 2'b10);

endmodule

// File: tb/tb_spot_actuator.sv
// Directed bench for spot_actuator: expected step pulses are queued when SPO is driven
// and compared against pulses captured from the DUT once the move settles.
module tb_spot_actuator;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned unbusy_steps = 0;
  int unsigned fall;
  int unsigned s;

  typedef struct {
    int unsigned c;
    logic        d;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  spot_actuator_if bus ();

  spot_actuator #(
    .STEPS_PER_POS(8),
    .STEP_DIV     (4),
    .SETTLE_CYC   (3),
    .LAMP_MAX     (15),
    .RAMP_DIV     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.step === 1'b1) begin
      obs_q.push_back('{cyc, bus.dir});
      if (bus.busy !== 1'b1) unbusy_steps++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_pulses(input int unsigned first, input int n, input logic d);
    for (int i = 0; i < n; i++) exp_q.push_back('{first + 4 * i, d});
  endtask

  task automatic wait_idle(input string tag, input int max, input logic [1:0] hold,
                           input logic lamp_fixed, output int unsigned fall_cyc);
    int         n = 0;
    bit         seen = 0;
    int         bad = 0;
    int         lbad = 0;
    logic [3:0] l0;
    l0 = bus.lamp;
    while (!(seen && bus.busy === 1'b0) && n < max) begin
      tick(1);
      n++;
      if (bus.busy === 1'b1) begin
        seen = 1;
        if (bus.at_pos !== hold) bad++;
      end
      if (lamp_fixed && bus.lamp !== l0) lbad++;
    end
    chk({tag, "_done"}, 32'(seen && bus.busy === 1'b0), 1);
    chk({tag, "_at_pos_hold"}, bad, 0);
    chk({tag, "_lamp_stable"}, lbad, 0);
    fall_cyc = cyc;
  endtask

  task automatic check_pulses(input string tag, input int unsigned fall_cyc);
    int unsigned ef;
    pulse_t      e, o;
    ef = exp_q[exp_q.size() - 1].c + 7;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    chk({tag, "_busy_fall"}, fall_cyc, ef);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_pulse_cyc"}, o.c, e.c);
      chk({tag, "_pulse_dir"}, 32'(o.d), 32'(e.d));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    bus.SPO = 3'b101;
    tick(2);
    rst = 1'b0;
    chk("rst_step", bus.step, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_at_pos", bus.at_pos, 2'b01);
    chk("rst_fault", bus.fault, 0);
    chk("rst_lamp", bus.lamp, 0);
    chk("rst_dir", bus.dir, 0);

    // First non-reset edge is edge 3; lamp reaches 15 at edge 33.
    tick(30);
    chk("lamp_up_edge32", bus.lamp, 14);
    tick(1);
    chk("lamp_up_edge33", bus.lamp, 15);
    tick(4);
    chk("lamp_up_hold", bus.lamp, 15);
    chk("idle_no_pulses", obs_q.size(), 0);

    bus.SPO = 3'b111;
    push_pulses(cyc + 3, 8, 1'b1);
    wait_idle("right", 200, 2'b01, 1'b1, fall);
    check_pulses("right", fall);
    chk("right_at_pos", bus.at_pos, 2'b11);

    bus.SPO = 3'b100;
    push_pulses(cyc + 3, 16, 1'b0);
    wait_idle("sweep", 300, 2'b11, 1'b1, fall);
    check_pulses("sweep", fall);
    chk("sweep_at_pos", bus.at_pos, 2'b00);

    bus.SPO = 3'b101;
    push_pulses(cyc + 3, 8, 1'b1);
    wait_idle("to_center", 200, 2'b00, 1'b1, fall);
    check_pulses("to_center", fall);
    chk("to_center_at_pos", bus.at_pos, 2'b01);

    // Retarget to Left while the third step period is in progress.
    bus.SPO = 3'b111;
    s = cyc + 1;
    push_pulses(s + 2, 3, 1'b1);
    tick(11);
    chk("rt_third_pulse", bus.step, 1);
    bus.SPO = 3'b100;
    push_pulses(s + 14, 11, 1'b0);
    wait_idle("retarget", 300, 2'b01, 1'b1, fall);
    check_pulses("retarget", fall);
    chk("retarget_at_pos", bus.at_pos, 2'b00);

    bus.SPO = 3'b101;
    push_pulses(cyc + 3, 8, 1'b1);
    wait_idle("center2", 200, 2'b00, 1'b1, fall);
    check_pulses("center2", fall);

    bus.SPO = 3'b110;
    chk("fault_lag", bus.fault, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("fault_high", bus.fault, 1);
    end
    bus.SPO = 3'b101;
    tick(1);
    chk("fault_clear", bus.fault, 0);
    tick(3);
    chk("fault_no_pulses", obs_q.size(), 0);
    chk("fault_busy", bus.busy, 0);
    chk("fault_at_pos", bus.at_pos, 2'b01);

    bus.SPO = 3'b001;
    tick(3);
    chk("lamp_dn_first", bus.lamp, 14);
    tick(2);
    chk("lamp_dn_second", bus.lamp, 13);
    tick(25);
    chk("lamp_dn_edge30", bus.lamp, 1);
    tick(1);
    chk("lamp_dn_zero", bus.lamp, 0);
    tick(4);
    chk("lamp_dn_hold", bus.lamp, 0);

    // Reset during a Center->Right move, after the second pulse.
    bus.SPO = 3'b111;
    s = cyc + 1;
    push_pulses(s + 2, 2, 1'b1);
    tick(7);
    chk("rm_second_pulse", bus.step, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rm_step", bus.step, 0);
    chk("rm_busy", bus.busy, 0);
    chk("rm_at_pos", bus.at_pos, 2'b01);
    chk("rm_lamp", bus.lamp, 0);
    push_pulses(s + 10, 8, 1'b1);
    wait_idle("rst_move", 200, 2'b01, 1'b0, fall);
    check_pulses("rst_move", fall);
    chk("rst_move_at_pos", bus.at_pos, 2'b11);

    chk("step_while_idle", unbusy_steps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spot_actuator.md
Name: spot_actuator

Overview:
- Receiving end of the 3-bit spotlight command bus (SPO) produced by the theater master/spotlight FSMs.
- Decodes the command into motor step/direction pulses that move the physical spotlight between Left, Center and Right.
- Ramps lamp brightness on and off.
- Reports the reached position and flags invalid position codes.

Parameters:
- STEPS_PER_POS, 8: motor steps between adjacent positions (>=1).
- STEP_DIV, 4: clocks per step period; step high 1 clock, low STEP_DIV-1 clocks (>=2).
- SETTLE_CYC, 3: clocks held in SETTLE after the final step before busy falls (>=1).
- LAMP_MAX, 15: full brightness value (fits in 4 bits).
- RAMP_DIV, 2: clocks per lamp increment/decrement (>=1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- SPO, input, 3: SPO[2] = lamp on/off; SPO[1:0] = position (00 Left, 01 Center, 11 Right, 10 invalid).
- step, output, 1: motor step pulse, one clock wide.
- dir, output, 1: motor direction (1 = toward Right, 0 = toward Left); valid while step is high.
- lamp, output, 4: lamp brightness, 0 to LAMP_MAX.
- busy, output, 1: high while moving or settling.
- at_pos, output, 2: last reached position code (00/01/11).
- fault, output, 1: high while the registered command position is 10.

Behaviour:
- SPO is registered into cmd_q every clock. All decisions use cmd_q, so there is 1 clock of input latency.
- Position counter pos spans 0 to 2*STEPS_PER_POS: Left = 0, Center = STEPS_PER_POS, Right = 2*STEPS_PER_POS.
- Target register tgt loads the decoded cmd_q[1:0] when the code is valid. Code 10 leaves tgt unchanged and drives fault=1 on the same cycle cmd_q holds 10. fault is not sticky.
- Reset values: pos = Center, tgt = Center, cmd_q = 3'b001, state IDLE, step=0, dir=0, lamp=0, busy=0, at_pos=01, fault=0, all counters 0.
- Motion FSM states: IDLE, STEP_HI, STEP_LO, SETTLE.
  - IDLE: if tgt != pos, set dir = (tgt > pos) and go to STEP_HI; busy=1 from the next clock. Otherwise stay; busy=0.
  - STEP_HI: step=1 for exactly 1 clock. pos moves by +1 (dir=1) or -1 (dir=0) on exit. Go to STEP_LO.
  - STEP_LO: step=0 for STEP_DIV-1 clocks. At the end, re-evaluate tgt:
    - tgt != pos: update dir, go to STEP_HI.
    - tgt == pos: go to SETTLE.
  - SETTLE: hold SETTLE_CYC clocks. On exit go to IDLE, set busy=0, load at_pos from pos. If tgt changed during SETTLE, IDLE starts a new move on the next clock.
- Retargeting is evaluated only at step-period boundaries. A period in progress always completes, and pos never leaves its range.
- A first step pulse appears 2 clocks after the SPO edge. Example: Center to Right with defaults = 8 pulses, 4 clocks apart; busy falls 3 clocks after the last STEP_LO ends.
- at_pos holds its last value while busy and updates only on SETTLE to IDLE. pos is always Left, Center or Right in IDLE.
- Lamp ramp runs independently of motion:
  - Lamp target = LAMP_MAX when cmd_q[2]=1, else 0.
  - Every RAMP_DIV clocks, lamp steps 1 toward its target. The divider runs only while lamp != target and clears when they are equal.
  - No overshoot and no wrap at 0 or LAMP_MAX.
- Reset mid-move takes effect on the next clock edge: step=0 immediately, pos returns to Center (the actuator homes mechanically to Center on reset), and lamp=0.

Test Plan:
- Reset: rst high 2 clocks, SPO=101 → step=0, busy=0, at_pos=01, fault=0, lamp=0. lamp then reaches 15 exactly 30 clocks after the first non-reset edge and stays at 15.
- Move right: idle at Center, SPO 101→111 at edge N → step first high in the clock after N+2, dir=1, 8 pulses spaced 4 clocks, busy=1 throughout, at_pos=11 and busy=0 exactly 3 clocks after the final STEP_LO.
- Full sweep: idle at Right, SPO→100 → 16 pulses with dir=0, at_pos stays 11 until settle, then becomes 00. lamp is unaffected by the move.
- Retarget: Center→Right, and SPO→100 during the 3rd step period → 3rd period completes, then dir=0 and 11 more pulses (14 total), final at_pos=00.
- Invalid code: idle at Center, SPO=110 for 5 clocks → fault=1 for 5 clocks with 1-clock lag, no step pulses, at_pos=01. SPO back to 101 → fault=0. Then SPO 1→0 on bit 2 with lamp at 15 → lamp decrements every 2 clocks and reaches 0 after 30.
- Reset mid-move: rst asserted 1 clock during a Center→Right move → next clock step=0, busy=0, at_pos=01, lamp=0. With SPO held at 111 after reset, the move restarts from Center and produces 8 pulses.
